apb3_bridge_slots: RTL and testbench
====================================

// Module: apb3_bridge_slots
// PURPOSE
//  Synthesisable AHB-Lite slave to APB3 master bridge with a parametrised number of peripheral slots.
//  Sits between the BFM/CPU AHB fabric and the APB peripherals (e.g. CoreUARTapb).
//  Adds over the fixed 16-slot bridge: unmapped-slot error, PSLVERR to HRESP mapping and a PREADY timeout watchdog.
// PARAMETERS
//  NUM_SLOTS      16  number of PSEL outputs, 1..16
//  ADDR_WIDTH     32  width of PADDR, 12..32
//  SLOT_LSB       24  HADDR bit where the 4-bit slot index starts
//  TIMEOUT_CYCLES 256 ACCESS cycles with PREADY=0 before abort; 0 disables the watchdog
// PORTS
//  HCLK       in  1            clock for both AHB and APB sides
//  HRESETN    in  1            asynchronous active-low reset
//  HSEL       in  1            AHB slave select
//  HADDR      in  32           AHB address
//  HWRITE     in  1            1 = write
//  HTRANS     in  2            AHB transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start an access
//  HSIZE      in  3            accepted but ignored (no byte strobes on APB3)
//  HWDATA     in  32           write data, valid in the data phase
//  HREADYIN   in  1            AHB bus ready
//  HREADYOUT  out 1            slave ready
//  HRESP      out 1            0 = OKAY, 1 = ERROR
//  HRDATA     out 32           read data
//  PSEL       out NUM_SLOTS    one-hot APB select
//  PADDR      out ADDR_WIDTH   APB address, HADDR[ADDR_WIDTH-1:0]
//  PWRITE     out 1            APB direction
//  PENABLE    out 1            APB access phase
//  PWDATA     out 32           APB write data
//  PRDATA     in  32           APB read data
//  PREADY     in  1            APB ready
//  PSLVERR    in  1            APB error
//  TIMEOUT    out 1            one-cycle pulse when the watchdog aborts an access
// BEHAVIOUR
//  Reset: asynchronous, takes effect immediately (including mid-access). Resets to IDLE.
//   Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HREADYOUT=1, HRESP=0, HRDATA=0, TIMEOUT=0.
//  Accept: HSEL & HREADYIN & HTRANS[1] is sampled on a rising edge; HADDR and HWRITE are registered.
//   slot = HADDR[SLOT_LSB+3:SLOT_LSB].
//  Idle traffic: IDLE/BUSY transfers, or HSEL=0, get a zero-wait OKAY.
//  FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
//   IDLE   -> WDATA if write, SETUP if read, ERR1 if slot>=NUM_SLOTS (unmapped: no APB cycle).
//   WDATA  -> SETUP. HREADYOUT=0. HWDATA is captured into PWDATA.
//   SETUP  -> ACCESS. PSEL[slot]=1, PENABLE=0, HREADYOUT=0.
//   ACCESS: PSEL=1, PENABLE=1.
//     PREADY=1, PSLVERR=0: HREADYOUT=1, HRESP=0, HRDATA=PRDATA (read), done.
//     PREADY=1, PSLVERR=1: HREADYOUT=0, go to ERR1.
//     PREADY=0: HREADYOUT=0, wait counter increments.
//       When the counter reaches TIMEOUT_CYCLES: drop PSEL/PENABLE, pulse TIMEOUT, go to ERR1.
//   ERR1   -> ERR2. HREADYOUT=0, HRESP=1, PSEL=0.
//   ERR2: HREADYOUT=1, HRESP=1; completes the AHB two-cycle error response.
//  Back-to-back: the ACCESS-done or ERR2 cycle also samples a new address phase.
//   A new access goes straight to WDATA, SETUP or ERR1 with no idle cycle; otherwise -> IDLE.
//  Latency with PREADY tied high:
//   read: 1 wait state (2 data-phase cycles).
//   write: 2 wait states (3 data-phase cycles).
//  PADDR/PWRITE stay stable from SETUP through the end of ACCESS.
//   PWDATA holds its value until the next write.
//  PSEL is never asserted for more than one slot. PENABLE is never high without PSEL.
//  The wait counter clears in SETUP and is 9+ bits, sized by $clog2(TIMEOUT_CYCLES+1).
//   It saturates and never wraps.
//  HRDATA is driven only in the read completion cycle, else 0. Write data is ignored on reads.
// TESTING
//  Read slot 2, addr 0x0200_0010, PREADY=1, PRDATA=0xCAFE_0001
//   -> PSEL=0x0004 for 2 cycles, HREADYOUT low 1 cycle, HRDATA=0xCAFE_0001, HRESP=0.
//  Write 0x1234_5678 to slot 0, PREADY low for 3 ACCESS cycles
//   -> PWDATA=0x1234_5678 from SETUP, PENABLE high 4 cycles, 5 wait states, OKAY.
//  NUM_SLOTS=4, access to slot 7
//   -> no PSEL, HRESP=1 for 2 cycles, HREADYOUT 0 then 1.
//  PSLVERR=1 with PREADY=1 on a read -> two-cycle ERROR response, next transfer accepted in ERR2.
//  TIMEOUT_CYCLES=8, PREADY stuck 0
//   -> abort after 8 ACCESS cycles, TIMEOUT pulse, ERROR response.
//   Repeat with TIMEOUT_CYCLES=0 -> waits indefinitely.
//  HRESETN low during ACCESS -> PSEL/PENABLE fall the same instant, HREADYOUT=1.
//   After release, the next read completes normally.

Source files
------------

// File: rtl/apb3_bridge_slots.sv
// AHB-Lite slave to APB3 master bridge with a parametrised number of
// peripheral slots. Each AHB transfer becomes one APB SETUP/ACCESS cycle
// on the slot selected by HADDR[SLOT_LSB+3:SLOT_LSB]. The bridge returns a
// two-cycle AHB ERROR response for unmapped slots, for PSLVERR, and when
// the PREADY watchdog gives up on a stalled peripheral.

module apb3_bridge_slots #(
  parameter int NUM_SLOTS      = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int SLOT_LSB       = 24,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  // AHB-Lite slave side
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  // APB3 master side
  output logic [NUM_SLOTS-1:0]  PSEL,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  // Watchdog abort pulse
  output logic                  TIMEOUT
);

  // The wait counter is at least 9 bits wide and grows with the timeout.
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW > 9) ? CNT_RAW : 9;

  localparam logic             WD_EN    = (TIMEOUT_CYCLES != 0);
  // Count value seen in the last ACCESS cycle the watchdog allows.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [4:0]       SLOTS_L  = 5'(NUM_SLOTS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              slot_q, slot_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [3:0]              slot_in;
  logic                    unmapped_in;
  logic                    take;
  logic                    timeout_hit;
  logic                    psel_en;
  state_e                  start_state;

  // HSIZE, HTRANS[0] and the HADDR bits outside PADDR/slot carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{HSIZE, HTRANS[0], HADDR};

  // Address-phase decode: slot index, unmapped check and the first data-phase state.
  assign slot_in     = HADDR[SLOT_LSB+3:SLOT_LSB];
  assign unmapped_in = ({1'b0, slot_in} >= SLOTS_L);
  assign start_state = unmapped_in ? ST_ERR1 : (HWRITE ? ST_WDATA : ST_SETUP);

  // A new address phase is only sampled in cycles where the bridge is ready,
  // which covers IDLE, the ACCESS completion cycle and ERR2.
  assign take = HREADYOUT && HSEL && HREADYIN && HTRANS[1];

  // Watchdog fires in the ACCESS cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = WD_EN && (state_q == ST_ACCESS) && !PREADY && (cnt_q == CNT_LAST);

  // State register; reset is asynchronous so the APB strobes drop immediately.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of block ordering.
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred for state_d.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) state_d = start_state;
      end
      ST_WDATA:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR)   state_d = ST_ERR1;
          else if (take) state_d = start_state;
          else           state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2: begin
        state_d = take ? start_state : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state and the APB response.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    PENABLE   = 1'b0;
    TIMEOUT   = 1'b0;
    psel_en   = 1'b0;
    unique case (state_q)
      ST_IDLE:  ;
      ST_WDATA: HREADYOUT = 1'b0;
      ST_SETUP: begin
        psel_en   = 1'b1;
        HREADYOUT = 1'b0;
      end
      ST_ACCESS: begin
        psel_en = 1'b1;
        PENABLE = 1'b1;
        if (PREADY && !PSLVERR) begin
          HREADYOUT = 1'b1;
          if (!pwrite_q) HRDATA = PRDATA;
        end else begin
          HREADYOUT = 1'b0;
          TIMEOUT   = timeout_hit;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2:  HRESP = 1'b1;
      default:  ;
    endcase
  end

  // One-hot slot select; slot_q is always mapped whenever psel_en is set.
  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      PSEL[i] = psel_en && (slot_q == 4'(i));
    end
  end

  // Next values for the address/data/counter registers.
  always_comb begin
    slot_d   = slot_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    if (take) begin
      slot_d   = slot_in;
      paddr_d  = HADDR[ADDR_WIDTH-1:0];
      pwrite_d = HWRITE;
    end
    if (state_q == ST_WDATA) pwdata_d = HWDATA;
    if (state_q == ST_SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !PREADY && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Address, direction, write data and wait-counter registers.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      slot_q   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      slot_q   <= slot_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_apb3_bridge_slots.sv
// Self-checking bench for apb3_bridge_slots. Bridge A uses 4 slots and an
// 8-cycle watchdog; bridge B uses 16 slots with the watchdog disabled.
// AHB transfers come from a vector table; their expected responses go into a
// scoreboard queue when the address phase is driven and are popped when the
// bridge completes the data phase.

module tb_apb3_bridge_slots;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        hsel_a, hsel_b;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  logic        a_hreadyout, a_hresp, a_pwrite, a_penable, a_timeout;
  logic [31:0] a_hrdata, a_paddr, a_pwdata;
  logic [3:0]  a_psel;

  logic        b_hreadyout, b_hresp, b_pwrite, b_penable, b_timeout;
  logic [31:0] b_hrdata, b_paddr, b_pwdata;
  logic [15:0] b_psel;

  int check_cnt = 0;
  int err_cnt   = 0;

  always #5 HCLK = ~HCLK;

  apb3_bridge_slots #(.NUM_SLOTS(4), .ADDR_WIDTH(32), .SLOT_LSB(24), .TIMEOUT_CYCLES(8)) u_dut_a (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(hsel_a), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
    .HREADYOUT(a_hreadyout), .HRESP(a_hresp), .HRDATA(a_hrdata),
    .PSEL(a_psel), .PADDR(a_paddr), .PWRITE(a_pwrite), .PENABLE(a_penable), .PWDATA(a_pwdata),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .TIMEOUT(a_timeout)
  );

  apb3_bridge_slots #(.NUM_SLOTS(16), .ADDR_WIDTH(32), .SLOT_LSB(24), .TIMEOUT_CYCLES(0)) u_dut_b (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(hsel_b), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
    .HREADYOUT(b_hreadyout), .HRESP(b_hresp), .HRDATA(b_hrdata),
    .PSEL(b_psel), .PADDR(b_paddr), .PWRITE(b_pwrite), .PENABLE(b_penable), .PWDATA(b_pwdata),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .TIMEOUT(b_timeout)
  );

  // One AHB transfer with its APB slave behaviour and expected AHB response.
  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          stall;      // ACCESS cycles with PREADY=0 before PREADY=1
    logic        slverr;
    logic        exp_hresp;
    logic [31:0] exp_hrdata;
    int          exp_waits;  // data-phase cycles with HREADYOUT=0
    logic [3:0]  exp_psel;
    int          exp_en;     // cycles with PSEL and PENABLE high
    logic        exp_to;
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] prdata, input int stall, input logic slverr,
                              input logic ehresp, input logic [31:0] ehrdata, input int ewaits,
                              input logic [3:0] epsel, input int een, input logic eto);
    vec_t v;
    v.id = 0;          v.wr = wr;           v.addr = addr;         v.wdata = wdata;
    v.prdata = prdata; v.stall = stall;     v.slverr = slverr;     v.exp_hresp = ehresp;
    v.exp_hrdata = ehrdata; v.exp_waits = ewaits; v.exp_psel = epsel; v.exp_en = een;
    v.exp_to = eto;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives vecs[first..last] into bridge A, playing the APB slave, and checks
  // each completed transfer against the scoreboard. With b2b set, the next
  // address phase overlaps the completion cycle of the previous transfer.
  task automatic run_vecs(input int first, input int last, input bit b2b);
    int          nxt, cyc, waits, en, hresp_n;
    bit          busy, was_busy, inv_ok, to_seen;
    vec_t        cur, exp;
    logic [3:0]  psel_seen;
    logic [31:0] paddr_seen, pwdata_seen;
    nxt = first; cyc = 0; busy = 0; cur = vecs[first];
    waits = 0; en = 0; hresp_n = 0; inv_ok = 1; to_seen = 0;
    psel_seen = '0; paddr_seen = '0; pwdata_seen = '0;
    while ((nxt <= last || busy) && cyc < 400) begin
      @(negedge HCLK);
      cyc++;
      was_busy = busy;
      if (busy) HWDATA = cur.wdata;
      if (busy && a_psel != 4'd0 && a_penable) begin
        en++;
        PREADY      = (en > cur.stall);
        PSLVERR     = PREADY && cur.slverr;
        PRDATA      = cur.prdata;
        psel_seen   = a_psel;
        paddr_seen  = a_paddr;
        pwdata_seen = a_pwdata;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'hDEAD_BEEF;
      end
      #1;
      if (a_penable && a_psel == 4'd0) inv_ok = 0;
      if (!$onehot0(a_psel)) inv_ok = 0;
      if (a_timeout) to_seen = 1;
      if (busy) begin
        if (a_hresp) hresp_n++;
        if (!a_hreadyout) begin
          waits++;
        end else begin
          exp = sb_q.pop_front();
          check($sformatf("v%0d_hresp", exp.id), a_hresp, exp.exp_hresp);
          check($sformatf("v%0d_hrdata", exp.id), a_hrdata, exp.exp_hrdata);
          check($sformatf("v%0d_waits", exp.id), waits, exp.exp_waits);
          check($sformatf("v%0d_psel", exp.id), psel_seen, exp.exp_psel);
          check($sformatf("v%0d_penable_cycles", exp.id), en, exp.exp_en);
          check($sformatf("v%0d_timeout", exp.id), to_seen, exp.exp_to);
          check($sformatf("v%0d_err_cycles", exp.id), hresp_n, exp.exp_hresp ? 2 : 0);
          check($sformatf("v%0d_psel_invariants", exp.id), inv_ok, 1);
          if (exp.exp_psel != 4'd0)
            check($sformatf("v%0d_paddr", exp.id), paddr_seen, exp.addr);
          if (exp.exp_psel != 4'd0 && exp.wr)
            check($sformatf("v%0d_pwdata", exp.id), pwdata_seen, exp.wdata);
          busy = 0;
        end
      end
      if (nxt <= last && a_hreadyout && (b2b || !was_busy)) begin
        cur = vecs[nxt];
        sb_q.push_back(vecs[nxt]);
        nxt++;
        hsel_a = 1'b1; HTRANS = 2'b10; HADDR = cur.addr; HWRITE = cur.wr;
        busy = 1; waits = 0; en = 0; hresp_n = 0; inv_ok = 1; to_seen = 0;
        psel_seen = '0; paddr_seen = '0; pwdata_seen = '0;
      end else begin
        hsel_a = 1'b0; HTRANS = 2'b00;
      end
    end
    check("run_completed", {31'd0, busy || (nxt <= last)}, 32'd0);
    sb_q.delete();
  endtask

  initial begin
    bit stall_bad;
    int en_b;

    //            wr  addr          wdata         prdata        stl err hrsp hrdata        wts psel en to
    vecs[0]  = mk(0, 32'h0200_0010, 32'h0,        32'hCAFE_0001, 0,   0, 0, 32'hCAFE_0001, 1,  4'h4, 1, 0);
    vecs[1]  = mk(1, 32'h0000_0040, 32'h1234_5678, 32'hBAD0_BAD0, 3,  0, 0, 32'h0,         5,  4'h1, 4, 0);
    vecs[2]  = mk(0, 32'h0100_0004, 32'h0,        32'h5A5A_A5A5, 2,   0, 0, 32'h5A5A_A5A5, 3,  4'h2, 3, 0);
    vecs[3]  = mk(1, 32'h0300_0ABC, 32'hA5A5_0F0F, 32'hBAD0_BAD0, 0,  0, 0, 32'h0,         2,  4'h8, 1, 0);
    vecs[4]  = mk(0, 32'h0700_0000, 32'h0,        32'hBAD0_BAD0, 0,   0, 1, 32'h0,         1,  4'h0, 0, 0);
    vecs[5]  = mk(1, 32'h0400_0000, 32'hFFFF_0000, 32'hBAD0_BAD0, 0,  0, 1, 32'h0,         1,  4'h0, 0, 0);
    vecs[6]  = mk(0, 32'h0100_0008, 32'h0,        32'h1111_2222, 0,   1, 1, 32'h0,         3,  4'h2, 1, 0);
    vecs[7]  = mk(1, 32'h0200_0100, 32'h7777_8888, 32'hBAD0_BAD0, 1,  1, 1, 32'h0,         5,  4'h4, 2, 0);
    vecs[8]  = mk(0, 32'h0300_0000, 32'h0,        32'h3333_4444, 1000, 0, 1, 32'h0,        10, 4'h8, 8, 1);
    vecs[9]  = mk(0, 32'h0000_0FFC, 32'h0,        32'h0000_0009, 0,   0, 0, 32'h0000_0009, 1,  4'h1, 1, 0);
    vecs[10] = mk(0, 32'h0100_0010, 32'h0,        32'h5555_6666, 0,   1, 1, 32'h0,         3,  4'h2, 1, 0);
    vecs[11] = mk(0, 32'h0200_0014, 32'h0,        32'h2468_ACE0, 0,   0, 0, 32'h2468_ACE0, 1,  4'h4, 1, 0);
    vecs[12] = mk(1, 32'h0300_0018, 32'h1357_9BDF, 32'hBAD0_BAD0, 0,  0, 0, 32'h0,         2,  4'h8, 1, 0);
    vecs[13] = mk(0, 32'h0000_001C, 32'h0,        32'h0F0F_F0F0, 1,   0, 0, 32'h0F0F_F0F0, 2,  4'h1, 2, 0);
    for (int i = 0; i < 14; i++) vecs[i].id = i;

    HRESETN = 1'b0; hsel_a = 1'b0; hsel_b = 1'b0; HADDR = '0; HWRITE = 1'b0;
    HTRANS = 2'b00; HSIZE = 3'b010; HWDATA = '0; HREADYIN = 1'b1;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset values.
    #1;
    check("rst_psel", a_psel, 4'h0);
    check("rst_penable", a_penable, 1'b0);
    check("rst_pwrite", a_pwrite, 1'b0);
    check("rst_paddr", a_paddr, 32'h0);
    check("rst_pwdata", a_pwdata, 32'h0);
    check("rst_hreadyout", a_hreadyout, 1'b1);
    check("rst_hresp", a_hresp, 1'b0);
    check("rst_hrdata", a_hrdata, 32'h0);
    check("rst_timeout", a_timeout, 1'b0);
    repeat (2) @(negedge HCLK);
    HRESETN = 1'b1;

    // Single transfers with an idle cycle between them, then back-to-back.
    run_vecs(0, 9, 1'b0);
    run_vecs(10, 13, 1'b1);

    // Reset asserted in the middle of an ACCESS stall.
    @(negedge HCLK);
    hsel_a = 1'b1; HTRANS = 2'b10; HADDR = 32'h0100_0000; HWRITE = 1'b0;
    PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge HCLK);
    hsel_a = 1'b0; HTRANS = 2'b00;
    repeat (3) @(negedge HCLK);
    #1;
    check("mid_rst_pre_penable", a_penable, 1'b1);
    HRESETN = 1'b0;
    #1;
    check("mid_rst_psel", a_psel, 4'h0);
    check("mid_rst_penable", a_penable, 1'b0);
    check("mid_rst_hreadyout", a_hreadyout, 1'b1);
    check("mid_rst_hresp", a_hresp, 1'b0);
    @(negedge HCLK);
    HRESETN = 1'b1;
    run_vecs(9, 9, 1'b0);

    // Watchdog disabled: a stall of 300 cycles never aborts.
    @(negedge HCLK);
    hsel_b = 1'b1; HTRANS = 2'b10; HADDR = 32'h0500_0020; HWRITE = 1'b0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0BAD_F00D;
    @(negedge HCLK);
    hsel_b = 1'b0; HTRANS = 2'b00;
    stall_bad = 0; en_b = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (b_hreadyout || b_timeout || b_hresp) stall_bad = 1;
      if (b_penable) en_b++;
      @(negedge HCLK);
    end
    check("nt_no_abort", {31'd0, stall_bad}, 32'd0);
    check("nt_penable_cycles", en_b, 299);
    PREADY = 1'b1;
    #1;
    check("nt_hreadyout", b_hreadyout, 1'b1);
    check("nt_hrdata", b_hrdata, 32'h0BAD_F00D);
    check("nt_hresp", b_hresp, 1'b0);
    check("nt_psel", b_psel, 16'h0020);
    @(negedge HCLK);
    PREADY = 1'b0;
    #1;
    check("nt_idle_psel", b_psel, 16'h0000);
    check("nt_idle_hrdata", b_hrdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
